// File: rtl/uart_tx_fifo_pkg.sv
// Shared constants and launch-FSM encoding for the UART transmit FIFO.
package uart_tx_fifo_pkg;

    localparam int unsigned BYTE_W = 8;

    typedef enum logic [1:0] {
        StIdle     = 2'd0,
        StLaunch   = 2'd1,
        StWaitBusy = 2'd2,
        StWaitDone = 2'd3
    } tx_state_e;

endpackage

// File: rtl/uart_fifo_mem.sv
// DEPTH x BYTE_W register array: one synchronous write port, asynchronous head read.
module uart_fifo_mem
    import uart_tx_fifo_pkg::*;
#(
    parameter int unsigned DEPTH = 16,
    localparam int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk_50m,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [BYTE_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [BYTE_W-1:0] rd_data
);

    logic [BYTE_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_50m) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/uart_tx_fifo.sv
// Byte FIFO in front of a UART transmitter: queues host writes and launches one
// byte at a time, pacing on the transmitter's busy flag with a rise timeout.
module uart_tx_fifo
    import uart_tx_fifo_pkg::*;
#(
    parameter int unsigned DEPTH    = 16,
    parameter int unsigned WAIT_MAX = 15
) (
    input  logic                     clk_50m,
    input  logic                     rst,
    input  logic                     push,
    input  logic [BYTE_W-1:0]        push_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     ovf,
    input  logic                     ovf_clr,
    output logic [BYTE_W-1:0]        uart_din,
    output logic                     uart_wr_en,
    input  logic                     uart_tx_busy
);

    localparam int unsigned PTR_W  = $clog2(DEPTH);
    localparam int unsigned CNT_W  = PTR_W + 1;
    localparam int unsigned WAIT_W = $clog2(WAIT_MAX + 1);

    logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]  count_q;
    logic              ovf_q;
    logic [BYTE_W-1:0] uart_din_q;
    logic              uart_wr_en_q;
    logic [WAIT_W-1:0] wait_cnt_q;
    tx_state_e         state_q;
    logic [BYTE_W-1:0] head_data;
    logic              do_push, do_pop;

    assign full       = (count_q == CNT_W'(DEPTH));
    assign empty      = (count_q == '0);
    assign count      = count_q;
    assign ovf        = ovf_q;
    assign uart_din   = uart_din_q;
    assign uart_wr_en = uart_wr_en_q;

    assign do_push = push && !full;
    assign do_pop  = (state_q == StIdle) && !empty && !uart_tx_busy;

    uart_fifo_mem #(
        .DEPTH(DEPTH)
    ) u_mem (
        .clk_50m(clk_50m),
        .wr_en  (do_push),
        .wr_addr(wr_ptr_q),
        .wr_data(push_data),
        .rd_addr(rd_ptr_q),
        .rd_data(head_data)
    );

    // Pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk_50m) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
            // A dropped push outranks a clear in the same cycle.
            if (push && full) begin
                ovf_q <= 1'b1;
            end else if (ovf_clr) begin
                ovf_q <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk_50m) begin
        if (rst) begin
            state_q      <= StIdle;
            uart_din_q   <= '0;
            uart_wr_en_q <= 1'b0;
            wait_cnt_q   <= '0;
        end else begin
            uart_wr_en_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (do_pop) begin
                        state_q      <= StLaunch;
                        uart_din_q   <= head_data;
                        uart_wr_en_q <= 1'b1;
                    end
                end
                StLaunch: begin
                    state_q    <= StWaitBusy;
                    wait_cnt_q <= '0;
                end
                StWaitBusy: begin
                    if (uart_tx_busy) begin
                        state_q <= StWaitDone;
                    end else if (wait_cnt_q == WAIT_W'(WAIT_MAX - 1)) begin
                        // Busy never rose: treat the byte as sent.
                        state_q <= StIdle;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + WAIT_W'(1);
                    end
                end
                StWaitDone: begin
                    if (!uart_tx_busy) state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule
